// File: rtl/axi_stream_insert_header_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_insert_header_if
// Desc     : Data, output and header channels of the header inserter.
// Revision : 1.0
// ============================================================================
interface axi_stream_insert_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
  );
endinterface
`default_nettype wire

// File: rtl/axi_stream_insert_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_insert_header
// Desc     : Prepends the valid bytes of a header word to the next packet.
// Revision : 1.0
// ============================================================================
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_stream_insert_header_if.slave  axis
);
  localparam int CNT_WD = BYTE_CNT_WD + 1;
  localparam int SUM_WD = BYTE_CNT_WD + 2;

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_STREAM = 2'd1;
  localparam logic [1:0] C_ST_FLUSH  = 2'd2;
  localparam logic [1:0] C_ST_DRAIN  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [DATA_WD-1:0]      r_res;
  logic [CNT_WD-1:0]       r_res_cnt;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  logic                    w_ready_in;
  logic                    w_ready_insert;
  logic                    w_slot_free;
  logic                    w_hdr_hs;
  logic                    w_dat_hs;
  logic                    w_flush_ld;
  logic [DATA_WD-1:0]      w_data_msk;
  logic [CNT_WD-1:0]       w_data_cnt;
  logic [2*DATA_WD-1:0]    w_cat;
  logic [SUM_WD-1:0]       w_total;
  logic                    w_full;
  logic                    w_spill;
  logic [SUM_WD-1:0]       w_left;
  logic [CNT_WD-1:0]       w_hdr_len;
  logic [DATA_WD-1:0]      w_hdr_aligned;
  logic                    w_unused_keep_insert;

  function automatic logic [DATA_BYTE_WD-1:0] lead_ones(input logic [SUM_WD-1:0] n);
    lead_ones = ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  assign w_slot_free = !r_valid_out || axis.ready_out;
  assign w_hdr_hs    = axis.valid_insert && w_ready_insert;
  assign w_dat_hs    = axis.valid_in && w_ready_in;
  assign w_flush_ld  = (r_state == C_ST_FLUSH) && w_slot_free;

  // keep_insert only mirrors byte_insert_cnt, which is authoritative
  assign w_unused_keep_insert = ^axis.keep_insert;

  always_comb begin
    w_data_msk = '0;
    w_data_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (axis.keep_in[i]) begin
        w_data_msk[i*8 +: 8] = axis.data_in[i*8 +: 8];
        w_data_cnt           = w_data_cnt + CNT_WD'(1);
      end
    end
  end

  // Residual bytes sit left-aligned, so the new beat lands right behind them
  assign w_cat   = {r_res, {DATA_WD{1'b0}}}
                 | ({w_data_msk, {DATA_WD{1'b0}}} >> {r_res_cnt, 3'b000});
  assign w_total = SUM_WD'(r_res_cnt) + SUM_WD'(w_data_cnt);
  assign w_full  = w_total >= SUM_WD'(DATA_BYTE_WD);
  assign w_spill = w_total >  SUM_WD'(DATA_BYTE_WD);
  assign w_left  = w_full ? (w_total - SUM_WD'(DATA_BYTE_WD)) : '0;

  assign w_hdr_len     = CNT_WD'(axis.byte_insert_cnt) + CNT_WD'(1);
  assign w_hdr_aligned = axis.data_insert << {CNT_WD'(DATA_BYTE_WD) - w_hdr_len, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) r_state <= C_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE:   if (w_hdr_hs) w_state_nxt = C_ST_STREAM;
      C_ST_STREAM: if (w_dat_hs && axis.last_in) w_state_nxt = w_spill ? C_ST_FLUSH : C_ST_DRAIN;
      C_ST_FLUSH:  if (w_slot_free) w_state_nxt = C_ST_DRAIN;
      C_ST_DRAIN:  if (r_valid_out && axis.ready_out) w_state_nxt = C_ST_IDLE;
      default:     w_state_nxt = C_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready_in     = 1'b0;
    w_ready_insert = 1'b0;
    if (!rst) begin
      case (r_state)
        C_ST_IDLE:   w_ready_insert = 1'b1;
        C_ST_STREAM: w_ready_in     = w_slot_free;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res       <= '0;
      r_res_cnt   <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else begin
      if (w_hdr_hs) begin
        r_res     <= w_hdr_aligned;
        r_res_cnt <= w_hdr_len;
      end else if (w_dat_hs) begin
        r_res     <= w_full ? w_cat[DATA_WD-1:0] : '0;
        r_res_cnt <= CNT_WD'(w_left);
      end else if (w_flush_ld) begin
        r_res     <= '0;
        r_res_cnt <= '0;
      end

      if (w_dat_hs) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_cat[2*DATA_WD-1:DATA_WD];
        r_keep_out  <= lead_ones(w_total);
        r_last_out  <= axis.last_in && !w_spill;
      end else if (w_flush_ld) begin
        r_valid_out <= 1'b1;
        r_data_out  <= r_res;
        r_keep_out  <= lead_ones(SUM_WD'(r_res_cnt));
        r_last_out  <= 1'b1;
      end else if (axis.ready_out) begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign axis.ready_in     = w_ready_in;
  assign axis.ready_insert = w_ready_insert;
  assign axis.valid_out    = r_valid_out;
  assign axis.data_out     = r_data_out;
  assign axis.keep_out     = r_keep_out;
  assign axis.last_out     = r_last_out;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_insert_header.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_insert_header
// Desc     : Directed and randomized checks of the header inserter.
// Revision : 1.0
// ============================================================================
module tb_axi_stream_insert_header;
  typedef struct packed { logic [31:0] data; logic [1:0] cnt; } hdr_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; logic rin; logic rins; } mon_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  hdr_t  hdr_q[$];
  beat_t din_q[$];
  beat_t exp_q[$];
  mon_t  got_q[$];

  axi_stream_insert_header_if #(.DATA_WD(32)) bus();
  axi_stream_insert_header #(.DATA_WD(32)) dut (.clk(clk), .rst(rst), .axis(bus));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && bus.valid_out && bus.ready_out)
      got_q.push_back({bus.data_out, bus.keep_out, bus.last_out, bus.ready_in, bus.ready_insert});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte-stream model: header bytes then data bytes, re-chunked into 4-byte beats
  function automatic void model_packet(input hdr_t h, input beat_t b[$]);
    logic [7:0] q[$];
    beat_t o;
    for (int i = int'(h.cnt); i >= 0; i--) q.push_back(h.data[i*8 +: 8]);
    foreach (b[k]) begin
      int n = $countones(b[k].keep);
      for (int j = 0; j < n; j++) q.push_back(b[k].data[31-8*j -: 8]);
    end
    while (q.size() > 0) begin
      o = '0;
      for (int j = 0; j < 4 && q.size() > 0; j++) begin
        o.data[31-8*j -: 8] = q.pop_front();
        o.keep[3-j] = 1'b1;
      end
      o.last = (q.size() == 0);
      exp_q.push_back(o);
    end
  endfunction

  task automatic run(input int n_beats, input bit rnd, input int budget);
    bit hhs, dhs;
    int cyc = 0;
    while (got_q.size() < n_beats && cyc < budget) begin
      if (!bus.valid_insert && hdr_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        bus.valid_insert    = 1'b1;
        bus.data_insert     = hdr_q[0].data;
        bus.byte_insert_cnt = hdr_q[0].cnt;
        bus.keep_insert     = 4'((5'd2 << hdr_q[0].cnt) - 5'd1);
      end
      if (!bus.valid_in && din_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        bus.valid_in = 1'b1;
        bus.data_in  = din_q[0].data;
        bus.keep_in  = din_q[0].keep;
        bus.last_in  = din_q[0].last;
      end
      bus.ready_out = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      hhs = bus.valid_insert && bus.ready_insert;
      dhs = bus.valid_in && bus.ready_in;
      @(posedge clk); #1;
      if (hhs) begin void'(hdr_q.pop_front()); bus.valid_insert = 1'b0; end
      if (dhs) begin void'(din_q.pop_front()); bus.valid_in = 1'b0; end
      cyc++;
    end
    bus.ready_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0; bus.byte_insert_cnt = '0;
    bus.ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out} !== 38'd0) begin
      fails++; $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b, need all 0",
                        bus.valid_out, bus.data_out, bus.keep_out, bus.last_out);
    end
    tests++;
    if ({bus.ready_in, bus.ready_insert} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got rin=%b rins=%b, need 0/0", bus.ready_in, bus.ready_insert);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.ready_in, bus.ready_insert} !== 2'b01) begin
      fails++; $display("FAIL release_ready: got rin=%b rins=%b, need 0/1", bus.ready_in, bus.ready_insert);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    got_q.delete(); exp_q.delete();
    hdr_q.push_back('{32'hAABBCCDD, 2'd1});
    din_q.push_back('{32'h11223344, 4'hF, 1'b0});
    din_q.push_back('{32'h55667788, 4'hC, 1'b1});
    exp_q.push_back('{32'hCCDD1122, 4'hF, 1'b0});
    exp_q.push_back('{32'h33445566, 4'hF, 1'b1});
    hdr_q.push_back('{32'hA1A2A3A4, 2'd3});
    din_q.push_back('{32'hB1B2B3B4, 4'h8, 1'b1});
    exp_q.push_back('{32'hA1A2A3A4, 4'hF, 1'b0});
    exp_q.push_back('{32'hB1000000, 4'h8, 1'b1});
    run(4, 1'b0, 100);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL vec_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
        fails++; $display("FAIL vec_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_flush();
    got_q.delete(); exp_q.delete();
    hdr_q.push_back('{32'h000000EE, 2'd0});
    din_q.push_back('{32'h01020304, 4'hF, 1'b0});
    din_q.push_back('{32'h05060708, 4'hF, 1'b1});
    exp_q.push_back('{32'hEE010203, 4'hF, 1'b0});
    exp_q.push_back('{32'h04050607, 4'hF, 1'b0});
    exp_q.push_back('{32'h08000000, 4'h8, 1'b1});
    run(3, 1'b0, 100);
    tests++;
    if (got_q.size() != 3) begin
      fails++; $display("FAIL flush_count: got %0d beats, need 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
          fails++; $display("FAIL flush_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                            got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
      tests++;
      if ({got_q[0].rin, got_q[1].rin, got_q[2].rin} !== 3'b100) begin
        fails++; $display("FAIL flush_ready_in: got %b%b%b need 100", got_q[0].rin, got_q[1].rin, got_q[2].rin);
      end
    end
  endtask

  task automatic test_backpressure();
    hdr_t  h;
    beat_t b[$];
    got_q.delete(); exp_q.delete();
    h = '{32'h10111213, 2'd3};
    b.push_back('{32'h20212223, 4'hF, 1'b0});
    b.push_back('{32'h30313233, 4'hF, 1'b0});
    b.push_back('{32'h40414243, 4'hF, 1'b0});
    b.push_back('{32'h50515253, 4'hE, 1'b1});
    model_packet(h, b);
    hdr_q.push_back(h);
    din_q = b;
    run(1, 1'b0, 50);
    bus.ready_out = 1'b0;
    bus.valid_in = 1'b1; bus.data_in = din_q[0].data; bus.keep_in = din_q[0].keep; bus.last_in = din_q[0].last;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out, bus.ready_in} !== {1'b1, exp_q[1], 1'b0}) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b %h/%b/%b rin=%b need 1 %h/%b/%b rin=0", c, bus.valid_out,
                          bus.data_out, bus.keep_out, bus.last_out, bus.ready_in,
                          exp_q[1].data, exp_q[1].keep, exp_q[1].last);
      end
      @(posedge clk); #1;
    end
    run(exp_q.size(), 1'b0, 100);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL bp_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
        fails++; $display("FAIL bp_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_ordering();
    hdr_t  h;
    beat_t b[$];
    bit    hhs;
    got_q.delete(); exp_q.delete();
    h = '{32'h00C0C1C2, 2'd2};
    b.push_back('{32'hD0D1D2D3, 4'hF, 1'b0});
    b.push_back('{32'hE0E1E2E3, 4'hC, 1'b1});
    model_packet(h, b);
    din_q = b;
    bus.valid_in = 1'b1; bus.data_in = din_q[0].data; bus.keep_in = din_q[0].keep; bus.last_in = din_q[0].last;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.ready_in, bus.valid_out} !== 2'b00) begin
        fails++; $display("FAIL early_data%0d: got rin=%b vout=%b need 0/0", c, bus.ready_in, bus.valid_out);
      end
      @(posedge clk); #1;
    end
    hdr_q.push_back(h);
    hdr_q.push_back('{32'h12345678, 2'd0});
    run(exp_q.size(), 1'b0, 100);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ord_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last, got_q[i].rins} !== {exp_q[i], 1'b0}) begin
        fails++; $display("FAIL ord_beat%0d: got %h/%b/%b rins=%b need %h/%b/%b rins=0", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, got_q[i].rins, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    @(negedge clk);
    hhs = bus.valid_insert && bus.ready_insert;
    tests++;
    if (bus.ready_insert !== 1'b1) begin
      fails++; $display("FAIL ord_idle_ready_insert: got %b need 1", bus.ready_insert);
    end
    @(posedge clk); #1;
    if (hhs) begin void'(hdr_q.pop_front()); bus.valid_insert = 1'b0; end
    got_q.delete(); exp_q.delete(); b.delete();
    b.push_back('{32'h9ABCDEF0, 4'hF, 1'b1});
    model_packet('{32'h12345678, 2'd0}, b);
    din_q = b;
    run(exp_q.size(), 1'b0, 100);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ord2_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
        fails++; $display("FAIL ord2_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    hdr_t  h;
    beat_t b[$];
    beat_t t;
    int    nb;
    got_q.delete(); exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      h.cnt  = 2'($urandom_range(0, 3));
      h.data = $urandom;
      b.delete();
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        t.data = $urandom;
        t.last = (k == nb - 1);
        t.keep = t.last ? 4'(4'hF << (4 - $urandom_range(1, 4))) : 4'hF;
        b.push_back(t);
      end
      model_packet(h, b);
      hdr_q.push_back(h);
      foreach (b[k]) din_q.push_back(b[k]);
    end
    run(exp_q.size(), 1'b1, 3000);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
        fails++; $display("FAIL rand_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    hdr_q.delete(); din_q.delete();
    bus.valid_in = 1'b0; bus.valid_insert = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    beat_t b[$];
    got_q.delete(); exp_q.delete();
    hdr_q.push_back('{32'hCAFEF00D, 2'd1});
    for (int k = 0; k < 3; k++) din_q.push_back('{$urandom, 4'hF, 1'b0});
    run(1, 1'b0, 50);
    bus.ready_out = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.valid_out !== 1'b1) begin
      fails++; $display("FAIL midrst_pre_valid: got %b need 1", bus.valid_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.valid_insert = 1'b0;
    hdr_q.delete(); din_q.delete();
    @(negedge clk);
    tests++;
    if ({bus.ready_in, bus.ready_insert} !== 2'b00) begin
      fails++; $display("FAIL midrst_ready: got rin=%b rins=%b need 0/0", bus.ready_in, bus.ready_insert);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out} !== 38'd0) begin
      fails++; $display("FAIL midrst_outputs: got v=%b d=%h k=%b l=%b need all 0",
                        bus.valid_out, bus.data_out, bus.keep_out, bus.last_out);
    end
    tests++;
    if ({bus.ready_in, bus.ready_insert} !== 2'b01) begin
      fails++; $display("FAIL midrst_idle: got rin=%b rins=%b need 0/1", bus.ready_in, bus.ready_insert);
    end
    @(posedge clk); #1;
    got_q.delete();
    b.push_back('{32'hB1B2B3B4, 4'h8, 1'b1});
    model_packet('{32'hA1A2A3A4, 2'd3}, b);
    hdr_q.push_back('{32'hA1A2A3A4, 2'd3});
    din_q = b;
    run(exp_q.size(), 1'b0, 100);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL midrst_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if ({got_q[i].data, got_q[i].keep, got_q[i].last} !== exp_q[i]) begin
        fails++; $display("FAIL midrst_beat%0d: got %h/%b/%b need %h/%b/%b", i, got_q[i].data,
                          got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_flush();
    test_backpressure();
    test_ordering();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
